// File: rtl/address_generator2.sv
// address_generator2
//   Address sequencer for an in-place radix-2 NTT over one read port and one
//   write port of the coefficient RAM. A rising edge of `done` while idle runs
//   LOG_N butterfly stages. Each stage reads top/bottom operands of N/2
//   butterflies on alternate cycles, then drains for LATENCY cycles so the
//   next stage never reads a coefficient before it has been written back.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-low reset
//   done           start request (rising edge while idle starts a transform)
//   rdAddress      coefficient read address (registered)
//   wrAddress      write-back address = rdAddress delayed by LATENCY cycles
//   wrValid        write strobe = "was reading" delayed by LATENCY cycles
//   twiddleAddress twiddle ROM index for the current butterfly (registered)
module address_generator2 #(
  parameter int N       = 256,
  parameter int LOG_N   = 8,
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  output logic [LOG_N-1:0] rdAddress,
  output logic [LOG_N-1:0] wrAddress,
  output logic             wrValid,
  output logic [LOG_N-2:0] twiddleAddress
);

  localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LOG_N-1:0] CNT_LAST   = LOG_N'(N - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG_N - 1);
  localparam logic [DW-1:0]    DCNT_LAST  = DW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_stage, w_stage_nxt;
  logic [LOG_N-1:0] r_cnt, w_cnt_nxt;     // {butterfly index, operand select}
  logic [DW-1:0]    r_dcnt, w_dcnt_nxt;
  logic             r_done_d;
  logic             w_start;

  // Write-side delay line; index LATENCY-1 is the oldest entry.
  logic [LOG_N-1:0] r_dly_addr [LATENCY];
  logic [LATENCY-1:0] r_dly_vld;

  // Operand address: top = g*2*half + o, which is j with the group bits
  // shifted up one position; bottom adds half.
  function automatic logic [LOG_N-1:0] f_rd_addr(input logic [SW-1:0]    s,
                                                 input logic [LOG_N-2:0] j,
                                                 input logic             bot);
    logic [LOG_N-1:0] jj, half, lo_mask, top;
    jj      = {1'b0, j};
    half    = LOG_N'(1) << s;
    lo_mask = half - LOG_N'(1);
    top     = ((jj & ~lo_mask) << 1) | (jj & lo_mask);
    return bot ? (top | half) : top;
  endfunction

  function automatic logic [LOG_N-2:0] f_tw_addr(input logic [SW-1:0]    s,
                                                 input logic [LOG_N-2:0] j);
    logic [LOG_N-1:0] jj, o, tw;
    jj = {1'b0, j};
    o  = jj & ((LOG_N'(1) << s) - LOG_N'(1));
    tw = o << (STAGE_LAST - s);
    return tw[LOG_N-2:0];
  endfunction

  assign w_start = (r_state == S_IDLE) && done && !r_done_d;

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_READ;
          w_stage_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_READ: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + LOG_N'(1);
        end
      end
      S_DRAIN: begin
        if (r_dcnt == DCNT_LAST) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_READ;
            w_stage_nxt = r_stage + SW'(1);
            w_cnt_nxt   = '0;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + DW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_stage        <= '0;
      r_cnt          <= '0;
      r_dcnt         <= '0;
      r_done_d       <= 1'b0;
      rdAddress      <= '0;
      twiddleAddress <= '0;
      r_dly_vld      <= '0;
      for (int i = 0; i < LATENCY; i++) r_dly_addr[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_stage  <= w_stage_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_done_d <= done;

      // Addresses are computed for the cycle being entered; DRAIN holds.
      case (w_state_nxt)
        S_READ: begin
          rdAddress      <= f_rd_addr(w_stage_nxt, w_cnt_nxt[LOG_N-1:1], w_cnt_nxt[0]);
          twiddleAddress <= f_tw_addr(w_stage_nxt, w_cnt_nxt[LOG_N-1:1]);
        end
        S_IDLE: begin
          rdAddress      <= '0;
          twiddleAddress <= '0;
        end
        default: ;
      endcase

      // Butterfly pipeline mirror
      r_dly_vld[0]  <= (r_state == S_READ);
      r_dly_addr[0] <= rdAddress;
      for (int i = 1; i < LATENCY; i++) begin
        r_dly_vld[i]  <= r_dly_vld[i-1];
        r_dly_addr[i] <= r_dly_addr[i-1];
      end
    end
  end

  assign wrValid   = r_dly_vld[LATENCY-1];
  assign wrAddress = r_dly_addr[LATENCY-1];

endmodule

// File: tb/tb_address_generator2.sv
module tb_address_generator2;
  localparam int N     = 256;
  localparam int LOG_N = 8;
  localparam int LAT   = 4;
  localparam int SLEN  = N + LAT;
  localparam int TOTAL = LOG_N * SLEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             done;
  logic [LOG_N-1:0] rdAddress, wrAddress;
  logic             wrValid;
  logic [LOG_N-2:0] twiddleAddress;

  address_generator2 #(.N(N), .LOG_N(LOG_N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .done(done),
    .rdAddress(rdAddress), .wrAddress(wrAddress), .wrValid(wrValid),
    .twiddleAddress(twiddleAddress)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int exp_rd [TOTAL];
  int exp_tw [TOTAL];
  int exp_wv [TOTAL];
  int exp_wa [TOTAL];
  int wcnt   [N];

  typedef struct {
    int k; int rd; int tw; int wv; int wa;   // -1 = don't care
  } vec_t;
  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act, exp);
    end
  endtask

  // Reference sequence straight from the butterfly arithmetic.
  task automatic build_model();
    int k, half, o, g, top, tw, last_rd, last_tw;
    int rv [TOTAL];
    k = 0; last_rd = 0; last_tw = 0;
    for (int s = 0; s < LOG_N; s++) begin
      half = 1 << s;
      for (int j = 0; j < N/2; j++) begin
        o   = j % half;
        g   = j / half;
        top = g * 2 * half + o;
        tw  = (o * (1 << (LOG_N - 1 - s))) % (N/2);
        for (int b = 0; b < 2; b++) begin
          exp_rd[k] = top + b * half;
          exp_tw[k] = tw;
          rv[k]     = 1;
          last_rd   = exp_rd[k];
          last_tw   = tw;
          k++;
        end
      end
      for (int d = 0; d < LAT; d++) begin
        exp_rd[k] = last_rd;
        exp_tw[k] = last_tw;
        rv[k]     = 0;
        k++;
      end
    end
    for (int i = 0; i < TOTAL; i++) begin
      exp_wv[i] = (i >= LAT) ? rv[i-LAT]     : 0;
      exp_wa[i] = (i >= LAT) ? exp_rd[i-LAT] : 0;
    end
  endtask

  task automatic chk_zero(input string name, input int k);
    chk({name, "_rd"}, k, 32'(rdAddress), 0);
    chk({name, "_tw"}, k, 32'(twiddleAddress), 0);
    chk({name, "_wv"}, k, 32'(wrValid), 0);
  endtask

  // Entered at k=0 (the cycle after the start edge). Returns at k=abort_at
  // without advancing, or at k=TOTAL (idle) after a full run.
  task automatic run_transform(input int abort_at);
    int bad, first_bad;
    for (int a = 0; a < N; a++) wcnt[a] = 0;
    for (int k = 0; k < TOTAL; k++) begin
      checks++;
      if (rdAddress !== exp_rd[k] || twiddleAddress !== exp_tw[k] ||
          wrValid !== exp_wv[k][0] || (exp_wv[k] == 1 && wrAddress !== exp_wa[k])) begin
        failures++;
        $display("FAIL seq k=%0d got rd=%0d tw=%0d wv=%0d wa=%0d want rd=%0d tw=%0d wv=%0d wa=%0d",
                 k, rdAddress, twiddleAddress, wrValid, wrAddress,
                 exp_rd[k], exp_tw[k], exp_wv[k], exp_wa[k]);
      end
      foreach (tbl[t]) begin
        if (tbl[t].k == k) begin
          if (tbl[t].rd >= 0) chk("tbl_rd", k, 32'(rdAddress), tbl[t].rd);
          if (tbl[t].tw >= 0) chk("tbl_tw", k, 32'(twiddleAddress), tbl[t].tw);
          if (tbl[t].wv >= 0) chk("tbl_wv", k, 32'(wrValid), tbl[t].wv);
          if (tbl[t].wa >= 0) chk("tbl_wa", k, 32'(wrAddress), tbl[t].wa);
        end
      end
      if (wrValid === 1'b1) wcnt[wrAddress]++;
      if (k == abort_at) return;
      // done wiggles are ignored mid-transform; it ends held high
      done = (k < TOTAL - 10) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    bad = 0; first_bad = -1;
    for (int a = 0; a < N; a++)
      if (wcnt[a] != LOG_N) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL write_count addrs_wrong=%0d first=%0d got=%0d want=%0d",
               bad, first_bad, wcnt[first_bad], LOG_N);
    end
  endtask

  initial begin
    int cut;
    build_model();
    tbl = '{
      '{0,    0,   0,   0, -1},
      '{1,    1,   0,   0, -1},
      '{3,   -1,  -1,   0, -1},
      '{4,    4,   0,   1,  0},
      '{5,   -1,  -1,   1,  1},
      '{255,  255, 0,  -1, -1},
      '{259,  255, 0,   1, 255},
      '{260,  0,   0,   0, -1},
      '{261,  2,   0,  -1, -1},
      '{262,  1,   64, -1, -1},
      '{263,  3,   64, -1, -1},
      '{264,  4,   0,   1, 0},
      '{1820, 0,   0,  -1, -1},
      '{1821, 128, 0,  -1, -1},
      '{1822, 1,   1,  -1, -1},
      '{1823, 129, 1,  -1, -1},
      '{2074, 127, 127, -1, -1},
      '{2075, 255, 127, -1, -1},
      '{2079, 255, 127, 1, 255}
    };

    // Reset held with done high
    rst = 1'b0; done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_zero("reset", i);
      chk("reset_wa", i, 32'(wrAddress), 0);
    end
    // Release with done high counts as a rising edge
    rst = 1'b1;
    step();
    run_transform(-1);

    // done held high at completion: no restart
    for (int i = 0; i < 20; i++) begin
      chk_zero("idle_hold", TOTAL + i);
      step();
    end

    // One-cycle low then high: identical second run
    done = 1'b0; step();
    done = 1'b1; step();
    run_transform(-1);

    // Random idle gap, then abort at cycle 300
    done = 1'b0;
    repeat ($urandom_range(1, 6)) step();
    chk_zero("gap", -1);
    done = 1'b1; step();
    run_transform(300);
    rst = 1'b0; done = 1'($urandom_range(0, 1));
    step();
    chk_zero("abort", 301);
    chk("abort_wa", 301, 32'(wrAddress), 0);
    rst = 1'b1; done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_zero("post_abort", i);
    end
    done = 1'b1; step();

    // Abort at a random point, restart straight out of reset with done high
    cut = $urandom_range(LAT + 1, TOTAL - 20);
    run_transform(cut);
    rst = 1'b0; done = 1'b1;
    step();
    chk_zero("abort2", cut + 1);
    rst = 1'b1;
    step();
    run_transform(-1);
    for (int i = 0; i < 5; i++) begin
      chk_zero("final_idle", TOTAL + i);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
